// File: rtl/trig_capture_ctrl_pkg.sv
// Shared types and constants for the trigger/capture controller.
// Trigger-enable bit positions match the trig_en port layout.
package trig_capture_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

  localparam int TRIG_UART = 0;
  localparam int TRIG_SPI  = 1;
  localparam int TRIG_EXT  = 2;
  localparam int TRIG_SRCS = 3;

endpackage

// File: rtl/trig_capture_ctrl_ext_trig_sync.sv
// External trigger pin: two-flop synchroniser, history flop and a registered
// polarity-selected edge detect, giving a 3-clock pin-to-edge latency.
module trig_capture_ctrl_ext_trig_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_trig,
  input  logic ext_pol,
  output logic ext_edge
);

  logic meta_reg;
  logic sync_reg;
  logic hist_reg;
  logic edge_reg;
  logic edge_next;

  always_comb begin
    edge_next = ext_pol ? (sync_reg & ~hist_reg) : (~sync_reg & hist_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      hist_reg <= 1'b0;
      edge_reg <= 1'b0;
    end else begin
      meta_reg <= ext_trig;
      sync_reg <= meta_reg;
      hist_reg <= sync_reg;
      edge_reg <= edge_next;
    end
  end

  assign ext_edge = edge_reg;

endmodule

// File: rtl/trig_capture_ctrl.sv
// Circular sample-RAM capture sequencer: pre-trigger fill, armed, post-trigger
// count and done handshake, qualified by UART/SPI/external/software triggers.
module trig_capture_ctrl
  import trig_capture_ctrl_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              ack,
  input  logic              smpl_en,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [2:0]        trig_en,
  input  logic              ext_pol,
  input  logic              UARTtrig,
  input  logic              SPItrig,
  input  logic              ext_trig,
  input  logic              force_trig,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic              busy
);

  cap_state_t state_reg;
  cap_state_t state_next;

  logic [ADDR_W-1:0] waddr_reg;
  logic [ADDR_W-1:0] trig_addr_reg;
  logic [ADDR_W-1:0] tp_reg;
  logic [ADDR_W-1:0] pre_cnt_reg;
  logic [ADDR_W-1:0] post_cnt_reg;
  logic              pend_reg;

  logic                 ext_edge;
  logic [TRIG_SRCS-1:0] src_vec;
  logic [TRIG_SRCS-1:0] src_hit;
  logic                 hit;
  logic                 busy_int;
  logic                 wr;
  logic                 fill_last;
  logic                 post_last;

  trig_capture_ctrl_ext_trig_sync u_ext_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .ext_trig (ext_trig),
    .ext_pol  (ext_pol),
    .ext_edge (ext_edge)
  );

  assign src_vec[TRIG_UART] = UARTtrig;
  assign src_vec[TRIG_SPI]  = SPItrig;
  assign src_vec[TRIG_EXT]  = ext_edge;

  genvar gi;
  generate
    for (gi = 0; gi < TRIG_SRCS; gi++) begin : g_src
      assign src_hit[gi] = trig_en[gi] & src_vec[gi];
    end
  endgenerate

  assign hit = (|src_hit) | force_trig;
  assign wr  = smpl_en & busy_int;

  // Transitions happen on the write that completes a phase, so no extra
  // sample is ever written past the pre- or post-trigger budget.
  assign fill_last = wr && (pre_cnt_reg == ADDR_W'(1));
  assign post_last = wr && (pend_reg ? (post_cnt_reg == '0)
                                     : (post_cnt_reg == ADDR_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (run) state_next = (~trig_pos == '0) ? ARMED : FILL;
      FILL:  if (fill_last) state_next = ARMED;
      ARMED: if (hit) state_next = (smpl_en && tp_reg == '0) ? DONE : POST;
      POST:  if (post_last) state_next = DONE;
      DONE:  if (ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_int     = 1'b0;
    armed        = 1'b0;
    triggered    = 1'b0;
    capture_done = 1'b0;
    case (state_reg)
      FILL:  busy_int = 1'b1;
      ARMED: begin
        busy_int = 1'b1;
        armed    = 1'b1;
      end
      POST:  begin
        busy_int  = 1'b1;
        triggered = 1'b1;
      end
      DONE:  begin
        triggered    = 1'b1;
        capture_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Pre-trigger count DEPTH-1-tp is simply the bitwise inverse of tp.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_reg     <= '0;
      trig_addr_reg <= '0;
      tp_reg        <= '0;
      pre_cnt_reg   <= '0;
      post_cnt_reg  <= '0;
      pend_reg      <= 1'b0;
    end else begin
      if (state_reg == IDLE && run) begin
        waddr_reg   <= '0;
        tp_reg      <= trig_pos;
        pre_cnt_reg <= ~trig_pos;
      end else if (wr) begin
        waddr_reg <= waddr_reg + ADDR_W'(1);
      end

      if (state_reg == FILL && wr) begin
        pre_cnt_reg <= pre_cnt_reg - ADDR_W'(1);
      end

      if (state_reg == ARMED && hit) begin
        trig_addr_reg <= waddr_reg;
        post_cnt_reg  <= tp_reg;
        pend_reg      <= ~smpl_en;
      end else if (state_reg == POST && wr) begin
        if (pend_reg) begin
          pend_reg <= 1'b0;
        end else begin
          post_cnt_reg <= post_cnt_reg - ADDR_W'(1);
        end
      end
    end
  end

  assign busy      = busy_int;
  assign we        = wr;
  assign waddr     = waddr_reg;
  assign trig_addr = trig_addr_reg;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// Randomised bench for trig_capture_ctrl with a write-count based reference
// model; directed segments cover the wrap, ext latency, tp=0 and tp=max cases.
module tb_trig_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          ack = 1'b0;
  logic          smpl_en = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic [2:0]    trig_en = '0;
  logic          ext_pol = 1'b1;
  logic          uart_trig = 1'b0;
  logic          spi_trig = 1'b0;
  logic          ext_trig = 1'b0;
  logic          force_trig = 1'b0;
  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] trig_addr;
  logic          armed;
  logic          triggered;
  logic          capture_done;
  logic          busy;

  trig_capture_ctrl #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .ack          (ack),
    .smpl_en      (smpl_en),
    .trig_pos     (trig_pos),
    .trig_en      (trig_en),
    .ext_pol      (ext_pol),
    .UARTtrig     (uart_trig),
    .SPItrig      (spi_trig),
    .ext_trig     (ext_trig),
    .force_trig   (force_trig),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .armed        (armed),
    .triggered    (triggered),
    .capture_done (capture_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: capture described by the number of samples written.
  bit            m_active;
  bit            m_done;
  bit            m_trig;
  int            n;
  int            t;
  int            tp_m;
  logic [AW-1:0] taddr_m;
  logic [3:0]    ph;  // pin value sampled at the last four edges, [0] newest

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_done   = 0;
    m_trig   = 0;
    n        = 0;
    t        = 0;
    tp_m     = 0;
    taddr_m  = '0;
    ph       = '0;
  endtask

  // The pin reaches the edge detector output three clocks after it is sampled.
  function automatic logic m_ext_edge();
    return ext_pol ? (ph[2] & ~ph[3]) : (~ph[2] & ph[3]);
  endfunction

  function automatic logic m_armed();
    return m_active && !m_trig && (n >= DEPTH - 1 - tp_m);
  endfunction

  task automatic tick();
    logic arm;
    logic hitv;
    logic wev;
    logic [AW-1:0] wa_m;
    @(negedge clk);
    wa_m = AW'(n % DEPTH);
    chk("flags", {27'd0, busy, armed, triggered, capture_done, we},
        {27'd0, m_active, m_armed(), m_trig, m_done, smpl_en & m_active});
    chk("addr", {24'd0, waddr, trig_addr}, {24'd0, wa_m, taddr_m});
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      arm  = m_armed();
      hitv = (trig_en[0] & uart_trig) | (trig_en[1] & spi_trig) |
             (trig_en[2] & m_ext_edge()) | force_trig;
      wev  = smpl_en & m_active;
      if (!m_active && !m_done) begin
        if (run) begin
          m_active = 1;
          n        = 0;
          tp_m     = int'(trig_pos);
        end
      end else if (m_active) begin
        if (arm && hitv) begin
          m_trig  = 1;
          t       = n;
          taddr_m = AW'(n % DEPTH);
        end
        if (wev) n++;
        if (m_trig && n == t + tp_m + 1) begin
          m_active = 0;
          m_done   = 1;
        end
      end else if (ack) begin
        m_done = 0;
        m_trig = 0;
      end
      ph = {ph[2:0], ext_trig};
    end
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget && !m_done; c++) tick();
    chk("reach_done", capture_done, 1);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ack_idle", {busy, capture_done}, 0);
  endtask

  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int prob;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {busy, armed, triggered, capture_done, we, waddr, trig_addr}, 0);
    rst_n = 1'b1;
    tick();

    // tp=5, sample every cycle, UART trigger at waddr 12, wrap to 2.
    trig_pos = 4'd5; trig_en = 3'b001; smpl_en = 1'b1;
    start_run();
    chk("busy_after_run", busy, 1);
    for (int i = 0; i < 12; i++) begin
      uart_trig = (i == 3);
      spi_trig  = (i == 5) || (i == 10);
      tick();
      if (i == 8) chk("not_armed_w9", armed, 0);
      if (i == 9) chk("armed_w10", {armed, waddr}, {1'b1, 4'd10});
    end
    spi_trig  = 1'b0;
    uart_trig = 1'b1;
    tick();
    uart_trig = 1'b0;
    chk("trig_addr_12", trig_addr, 12);
    repeat (5) tick();
    chk("done_tp5", capture_done, 1);
    chk("wrap_waddr", waddr, 2);
    chk("we_in_done", we, 0);
    tick();
    do_ack();

    // Falling external edge, rising edge ignored, 3-clock latency.
    ext_pol = 1'b0; trig_en = 3'b100; trig_pos = 4'd3;
    repeat (4) tick();
    start_run();
    repeat (12) tick();
    chk("ext_armed", armed, 1);
    ext_trig = 1'b1;
    repeat (6) tick();
    chk("rise_no_hit", {armed, triggered}, 2'b10);
    ext_trig = 1'b0;
    repeat (3) tick();
    chk("ext_lat3", triggered, 0);
    tick();
    chk("ext_lat4", triggered, 1);
    wait_done(50);
    do_ack();

    // tp=0, sparse strobes, trigger between strobes.
    ext_pol = 1'b1; trig_en = 3'b000; trig_pos = 4'd0;
    repeat (4) tick();
    start_run();
    for (int c = 0; c < 200 && !m_done; c++) begin
      smpl_en    = (c % 4 == 0);
      force_trig = m_armed() && (c % 4 == 2);
      tick();
    end
    force_trig = 1'b0;
    chk("tp0_done", capture_done, 1);
    do_ack();

    // tp=15 goes straight to ARMED; run ignored in DONE; ack beats run.
    smpl_en = 1'b1; trig_pos = 4'd15;
    start_run();
    chk("tp15_armed", armed, 1);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    wait_done(40);
    start_run();
    chk("run_in_done", capture_done, 1);
    run = 1'b1;
    do_ack();
    run = 1'b0;

    // Asynchronous reset in the middle of POST.
    trig_pos = 4'd6;
    start_run();
    for (int c = 0; c < 40 && !m_armed(); c++) tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    repeat (2) tick();
    chk("in_post", triggered, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst", {busy, armed, triggered, capture_done, we, waddr, trig_addr}, 0);
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();

    // Randomised captures.
    for (int k = 0; k < 40; k++) begin
      trig_pos = AW'($urandom_range(0, DEPTH - 1));
      trig_en  = 3'($urandom);
      ext_pol  = 1'($urandom_range(0, 1));
      prob     = int'($urandom_range(20, 100));
      repeat (4) tick();
      start_run();
      for (int c = 0; c < 500 && !m_done; c++) begin
        smpl_en    = ($urandom_range(0, 99) < prob);
        uart_trig  = ($urandom_range(0, 15) == 0);
        spi_trig   = ($urandom_range(0, 15) == 0);
        force_trig = (c > 300) || ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 7) == 0) ext_trig = ~ext_trig;
        run        = ($urandom_range(0, 31) == 0);
        ack        = ($urandom_range(0, 31) == 0);
        tick();
      end
      uart_trig = 1'b0; spi_trig = 1'b0; force_trig = 1'b0; run = 1'b0; ack = 1'b0;
      chk("rand_done", capture_done, 1);
      $display("capture %0d tp=%0d trig_addr=%0d waddr=%0d", k, trig_pos, trig_addr, waddr);
      repeat ($urandom_range(0, 3)) begin
        run = 1'($urandom_range(0, 1));
        tick();
      end
      run = 1'($urandom_range(0, 1));
      do_ack();
      run = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trig_capture_ctrl.md
Name: trig_capture_ctrl

Overview:
Downstream consumer of the UART and SPI protocol trigger pulses. It qualifies those pulses and an external edge trigger against an enable mask. It sequences a circular sample-RAM capture: pre-trigger fill, armed, post-trigger count, done. It produces the RAM write strobe and address, the trigger address, and a capture-done handshake to the host command block.

Parameters:
ADDR_W, 9, sample RAM address width; DEPTH = 2**ADDR_W entries.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
run  in  1  1-cycle pulse: start a capture (honoured only in IDLE)
ack  in  1  1-cycle pulse: host has read RAM; DONE -> IDLE
smpl_en  in  1  sample strobe from decimator; one RAM write per strobe while capturing
trig_pos  in  ADDR_W  post-trigger sample count; latched on accepted run
trig_en  in  3  source enables: [0] UARTtrig, [1] SPItrig, [2] external edge
ext_pol  in  1  external edge polarity: 1 = rising, 0 = falling
UARTtrig  in  1  1-cycle match pulse from UART trigger block
SPItrig  in  1  1-cycle match pulse from SPI trigger block
ext_trig  in  1  asynchronous external trigger pin
force_trig  in  1  1-cycle software trigger; ignores trig_en
we  out  1  RAM write enable
waddr  out  ADDR_W  RAM write address
trig_addr  out  ADDR_W  RAM address that holds the trigger sample
armed  out  1  high in ARMED
triggered  out  1  high in POST and DONE
capture_done  out  1  high in DONE
busy  out  1  high in FILL, ARMED and POST

Behaviour:
- Reset: state IDLE. waddr, trig_addr, counters and sync flops are 0. All 1-bit outputs are 0.
- ext_trig path: two-flop synchroniser plus one history flop.
  - ext_edge = (sync & ~hist) when ext_pol=1; (~sync & hist) when ext_pol=0.
  - Pin-to-ext_edge latency is 3 clk.
- hit = |(trig_en & {ext_edge, SPItrig, UARTtrig}) | force_trig. Evaluated combinationally every cycle; never latched outside ARMED.
- we = smpl_en & busy (combinational). waddr increments modulo DEPTH on every write; DEPTH-1 wraps to 0.
- IDLE:
  - On run: waddr <= 0.
  - trig_pos latched to tp.
  - pre_cnt loaded with DEPTH-1-tp.
  - If DEPTH-1-tp == 0, go to ARMED; otherwise go to FILL.
- FILL:
  - Each write decrements pre_cnt. The write that takes pre_cnt to 0 moves the FSM to ARMED on the next cycle.
  - hit is ignored in FILL.
- ARMED:
  - Writes continue and the buffer wraps.
  - On hit: trig_addr <= waddr (the current-cycle write address if smpl_en=1, else the next write address). post_cnt <= tp. Go to POST.
  - If hit and smpl_en coincide, that write is the trigger sample and is not counted in post_cnt.
  - If no hit ever occurs (trig_en=0, no force), the FSM stays in ARMED indefinitely.
- POST:
  - Each write decrements post_cnt.
  - When post_cnt == 0 and no trigger-sample write is pending, go to DONE. Total samples after trigger = tp.
  - tp = 0: DONE is entered the cycle after the trigger sample has been written. If the trigger-sample write is still pending (hit without smpl_en), POST waits for one write first.
  - The buffer holds DEPTH-1-tp pre-trigger samples, 1 trigger sample and tp post-trigger samples.
  - The oldest sample is at trig_addr+tp+1 mod DEPTH.
- DONE:
  - we = 0. trig_addr and waddr hold.
  - ack moves to IDLE; capture_done falls the cycle after ack.
- run outside IDLE is ignored. ack outside DONE is ignored. Simultaneous run and ack in DONE: ack wins, run is dropped.
- trig_pos changes after latching have no effect until the next run.
- Asynchronous reset mid-capture: immediate return to IDLE, outputs as reset. RAM contents are undefined to the host.

Decomposition:
- Shared package: typedef enum {IDLE, FILL, ARMED, POST, DONE} cap_state_t; trigger-enable bit index constants TRIG_UART=0, TRIG_SPI=1, TRIG_EXT=2.
- One sub-module is natural: ext_trig_sync (two-flop synchroniser + polarity edge detect, outputs ext_edge).

Test Plan:
- ADDR_W=4, trig_pos=5, smpl_en every cycle, run -> busy next cycle; armed after exactly 10 writes (waddr=10).
- Then UARTtrig pulse with trig_en=3'b001 on the cycle waddr=12 -> trig_addr=12; capture_done after writes at 13..17 (5 post); waddr=2 after wrap; we=0 in DONE.
- trig_en=3'b001, SPItrig and UARTtrig pulsed during FILL -> no trigger. In ARMED, SPItrig only -> stays armed. force_trig -> triggered.
- ext_pol=0, trig_en=3'b100, ext_trig falls mid-ARMED -> hit exactly 3 clk later; a rising edge alone produces no hit.
- trig_pos=0, smpl_en every 4th cycle, hit between strobes -> trig_addr = next write address; DONE one cycle after that write.
- trig_pos=15 (ADDR_W=4) -> IDLE goes straight to ARMED. In DONE: run ignored, ack -> IDLE; rst_n asserted mid-POST -> all outputs 0 immediately.
